// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        REQ_IF,
        REQ_DM
    } req_id_e;

    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive fetch losses; at_limit lets fetch win the next arbitration.
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port with a fixed
// IDLE -> ACCESS -> RESP cycle; data wins unless fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int W            = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic         if_ack,
    output logic [W-1:0] if_rdata,
    input  logic         dm_req,
    input  logic         dm_we,
    input  logic [W-1:0] dm_addr,
    input  logic [W-1:0] dm_wdata,
    output logic         dm_ack,
    output logic [W-1:0] dm_rdata,
    output logic         err,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [W-1:0] mem_rdata
);

    state_e         r_state;
    state_e         w_next;
    req_id_e        r_win;
    req_id_e        w_win;
    logic [W-1:0]   r_addr;
    logic [W-1:0]   r_wdata;
    logic           r_we;
    logic [W-1:0]   r_if_rdata;
    logic [W-1:0]   r_dm_rdata;
    logic [W-1:0]   w_rdata;
    logic           w_grant;
    logic           w_at_limit;
    logic           w_unal;
    logic           w_inc;
    logic           w_clr;

    assign w_win   = (dm_req && !(w_at_limit && if_req)) ? REQ_DM : REQ_IF;
    assign w_grant = (r_state == IDLE) && (if_req || dm_req);
    assign w_unal  = |r_addr[1:0];

    // A sampled if_req=0 in IDLE breaks the losing streak even with no grant.
    assign w_inc = w_grant && (w_win == REQ_DM) && if_req;
    assign w_clr = (r_state == IDLE) && (!if_req || (w_win == REQ_IF));

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_inc),
        .clr      (w_clr),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (if_req || dm_req) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win   <= REQ_IF;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_grant) begin
            r_win   <= w_win;
            r_addr  <= (w_win == REQ_DM) ? dm_addr  : if_addr;
            r_wdata <= (w_win == REQ_DM) ? dm_wdata : '0;
            r_we    <= (w_win == REQ_DM) ? dm_we    : 1'b0;
        end
    end

    // Stores and suppressed (unaligned) accesses return zero data.
    assign w_rdata = (r_we || w_unal) ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (r_state == ACCESS) begin
            if (r_win == REQ_IF) r_if_rdata <= w_rdata;
            else                 r_dm_rdata <= w_rdata;
        end
    end

    // reset gates the write strobe directly so an in-flight store cannot land.
    assign mem_read  = (r_state == ACCESS) && !r_we && !w_unal;
    assign mem_write = (r_state == ACCESS) && r_we && !w_unal && !reset;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack   = (r_state == RESP) && (r_win == REQ_IF);
    assign dm_ack   = (r_state == RESP) && (r_win == REQ_DM);
    assign err      = (r_state == RESP) && w_unal;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected acks/probes, a negedge monitor checks them.
module tb_mem_port_arbiter;

    localparam int W = 32;
    localparam int P_RST = 0, P_MEMRD = 1, P_MEMWR = 2, P_MEMADDR = 3;

    logic         clk, reset;
    logic         if_req, dm_req, dm_we;
    logic [W-1:0] if_addr, dm_addr, dm_wdata;
    logic         if_ack, dm_ack, err, mem_read, mem_write;
    logic [W-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(4), .W(W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: untouched words read back a fixed pattern.
    logic [31:0] mem [256];
    bit          mem_wr [256];

    function automatic logic [31:0] init_val(logic [7:0] idx);
        if (idx == 8'd10) return 32'h0050_0093;
        if (idx == 8'd64) return 32'h1122_3344;
        return {24'hA5A5A5, idx};
    endfunction

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[9:2]]    <= mem_wdata;
            mem_wr[mem_addr[9:2]] <= 1'b1;
        end
    end
    assign mem_rdata = mem_wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_val(mem_addr[9:2]);

    typedef struct { bit dm; logic [31:0] data; bit err; int at; } exp_t;
    typedef struct { int kind; logic [31:0] val; int at; } probe_t;
    exp_t   sb[$];
    probe_t pq[$];
    bit     done = 1'b0;
    bit     hold_dm = 1'b0;
    int     tests = 0, fails = 0;

    task automatic push_exp(bit dm, logic [31:0] d, bit e, int at);
        exp_t x;
        x.dm = dm; x.data = d; x.err = e; x.at = at;
        sb.push_back(x);
    endtask

    task automatic probe(int kind, logic [31:0] val, int at);
        probe_t p;
        p.kind = kind; p.val = val; p.at = at;
        pq.push_back(p);
    endtask

    function automatic logic [31:0] probe_val(int kind);
        case (kind)
            P_RST:   return {27'b0, if_ack, dm_ack, err, mem_read, mem_write}
                            | mem_addr | mem_wdata | if_rdata | dm_rdata;
            P_MEMRD: return {31'b0, mem_read};
            P_MEMWR: return {31'b0, mem_write};
            default: return mem_addr;
        endcase
    endfunction

    exp_t        m_e;
    probe_t      m_p;
    logic [31:0] m_act;

    always @(negedge clk) begin
        if (if_ack && dm_ack) begin
            tests++; fails++;
            $display("FAIL dual_ack cyc=%0d got both acks, want at most one", cyc);
        end
        if (if_ack || dm_ack) begin
            tests++;
            m_act = dm_ack ? dm_rdata : if_rdata;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack cyc=%0d got dm=%0d data=%h err=%0d, want none",
                         cyc, dm_ack, m_act, err);
            end else begin
                m_e = sb.pop_front();
                if (m_e.dm != dm_ack || m_e.data != m_act || m_e.err != err || m_e.at != cyc) begin
                    fails++;
                    $display("FAIL ack got dm=%0d data=%h err=%0d cyc=%0d, want dm=%0d data=%h err=%0d cyc=%0d",
                             dm_ack, m_act, err, cyc, m_e.dm, m_e.data, m_e.err, m_e.at);
                end
            end
        end
        while (sb.size() > 0 && sb[0].at < cyc) begin
            m_e = sb.pop_front();
            tests++; fails++;
            $display("FAIL missing_ack got none by cyc=%0d, want dm=%0d data=%h at cyc=%0d",
                     cyc, m_e.dm, m_e.data, m_e.at);
        end
        while (pq.size() > 0 && pq[0].at <= cyc) begin
            m_p = pq.pop_front();
            tests++;
            m_act = probe_val(m_p.kind);
            if (m_p.at != cyc || m_act != m_p.val) begin
                fails++;
                $display("FAIL probe%0d cyc=%0d got %h, want %h at cyc=%0d",
                         m_p.kind, cyc, m_act, m_p.val, m_p.at);
            end
        end
        if (done || cyc > 3000) begin
            tests++;
            if (!done || sb.size() != 0 || pq.size() != 0) begin
                fails++;
                $display("FAIL drain done=%0d got %0d acks/%0d probes pending, want 0/0",
                         done, sb.size(), pq.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Advance one cycle; requesters drop req in the cycle after their ack.
    task automatic tick();
        bit ia, da;
        @(negedge clk);
        ia = if_ack;
        da = dm_ack;
        @(posedge clk);
        #1;
        if (ia) if_req = 1'b0;
        if (da && !hold_dm) dm_req = 1'b0;
    endtask

    int c;

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        probe(P_RST, 32'h0, cyc);
        tick();

        // Fetch alone
        c = cyc;
        if_req = 1'b1; if_addr = 32'h28;
        probe(P_MEMRD, 32'h1, c + 1);
        probe(P_MEMADDR, 32'h28, c + 1);
        probe(P_MEMRD, 32'h0, c + 2);
        push_exp(1'b0, 32'h0050_0093, 1'b0, c + 2);
        repeat (4) tick();

        // Collision: data first, fetch in the following IDLE
        c = cyc;
        if_req = 1'b1; if_addr = 32'h2C;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        push_exp(1'b1, 32'h1122_3344, 1'b0, c + 2);
        push_exp(1'b0, 32'hA5A5_A50B, 1'b0, c + 5);
        repeat (7) tick();

        // Starvation: four data grants, then fetch, then data again
        c = cyc;
        hold_dm = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h28;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 32'h1122_3344, 1'b0, c + 2 + 3 * k);
        push_exp(1'b0, 32'h0050_0093, 1'b0, c + 14);
        push_exp(1'b1, 32'h1122_3344, 1'b0, c + 17);
        repeat (16) tick();
        hold_dm = 1'b0;
        repeat (4) tick();

        // Unaligned store is suppressed
        c = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h102; dm_wdata = 32'h55;
        probe(P_MEMWR, 32'h0, c + 1);
        probe(P_MEMRD, 32'h0, c + 1);
        probe(P_MEMWR, 32'h0, c + 2);
        push_exp(1'b1, 32'h0, 1'b1, c + 2);
        repeat (4) tick();

        // Reset during ACCESS of a store
        c = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        tick();
        reset = 1'b1;
        dm_req = 1'b0; dm_we = 1'b0;
        probe(P_MEMWR, 32'h0, c + 1);
        probe(P_RST, 32'h0, c + 1);
        tick();
        reset = 1'b0;
        tick();

        // 0x40 must still hold its original contents
        c = cyc;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        push_exp(1'b1, 32'hA5A5_A510, 1'b0, c + 2);
        repeat (4) tick();

        // Store 7 then load it back
        c = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h7;
        probe(P_MEMWR, 32'h1, c + 1);
        push_exp(1'b1, 32'h0, 1'b0, c + 2);
        repeat (4) tick();
        c = cyc;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        push_exp(1'b1, 32'h7, 1'b0, c + 2);
        repeat (4) tick();

        // Unaligned fetch
        c = cyc;
        if_req = 1'b1; if_addr = 32'h29;
        probe(P_MEMRD, 32'h0, c + 1);
        push_exp(1'b0, 32'h0, 1'b1, c + 2);
        repeat (4) tick();

        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL finish monitor did not end the run");
        $fatal(1);
    end

endmodule
